// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers hex digits from a scanned active-low 7-segment bus
// Samples are deglitched for STABLE_CYCLES before a single accept per stable window.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [6:0]            i_seg,
  input  logic [DIGITS-1:0]     i_an,
  output logic [4*DIGITS-1:0]   o_num,
  output logic [DIGITS-1:0]     o_vld,
  output logic                  o_upd,
  output logic [DW-1:0]         o_dig,
  output logic                  o_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                 state_q;
  logic [DIGITS+6:0]      smp_q, smp_d;
  logic [CW-1:0]          cnt_q;
  logic [4*DIGITS-1:0]    num_q;
  logic [DIGITS-1:0]      vld_q;
  logic                   upd_q, err_q;
  logic [DW-1:0]          dig_q;

  logic                   chg, sel_ok_d, accept;
  logic [DW-1:0]          dig_k;
  logic [4:0]             dec;

  function automatic logic one_hot_low(input logic [DIGITS-1:0] an);
    int zeros;
    zeros = 0;
    for (int i = 0; i < DIGITS; i++) if (!an[i]) zeros++;
    return zeros == 1;
  endfunction

  function automatic logic [DW-1:0] low_index(input logic [DIGITS-1:0] an);
    logic [DW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++) if (!an[i]) idx = DW'(i);
    return idx;
  endfunction

  // {legal, value}; blank and illegal patterns both report legal=0
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h10;
      7'b1001111: return 5'h11;
      7'b0010010: return 5'h12;
      7'b0000110: return 5'h13;
      7'b1001100: return 5'h14;
      7'b0100100: return 5'h15;
      7'b0100000: return 5'h16;
      7'b0001111: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0000100: return 5'h19;
      7'b0001000: return 5'h1A;
      7'b1100000: return 5'h1B;
      7'b0110001: return 5'h1C;
      7'b1000010: return 5'h1D;
      7'b0110000: return 5'h1E;
      7'b0111000: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  always_comb begin
    smp_d    = {i_an, i_seg};
    chg      = (smp_d != smp_q);
    sel_ok_d = one_hot_low(i_an);
    dig_k    = low_index(smp_q[DIGITS+6:7]);
    dec      = seg_decode(smp_q[6:0]);
    accept   = (state_q == SETTLE) && (cnt_q == CNT_MAX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      vld_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      smp_q <= smp_d;
      upd_q <= 1'b0;
      err_q <= 1'b0;
      if (chg) begin
        cnt_q   <= '0;
        state_q <= sel_ok_d ? SETTLE : IDLE;
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (accept) state_q <= HOLD;
      end
      // Accept works on the already-stable sample, even if the bus moves on this edge
      if (accept) begin
        dig_q <= dig_k;
        if (dec[4]) begin
          num_q[4*dig_k +: 4] <= dec[3:0];
          vld_q[dig_k]        <= 1'b1;
          upd_q               <= 1'b1;
        end else if (smp_q[6:0] == 7'h7F) begin
          vld_q[dig_k] <= 1'b0;
          upd_q        <= 1'b1;
        end else begin
          vld_q[dig_k] <= 1'b0;
          err_q        <= 1'b1;
        end
      end
    end
  end

  assign o_num = num_q;
  assign o_vld = vld_q;
  assign o_upd = upd_q;
  assign o_err = err_q;
  assign o_dig = dig_q;

endmodule
